control_sequencer: RTL

//  T-state control sequencer for the 8-bit bus CPU. It sits directly upstream of every

---
 rtl/control_sequencer_if.sv | 60 ++++++
 rtl/control_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Control sequencer bundle: run/opcode in, T-state, halt flag
// and every register strobe / bus-source select out.
interface control_sequencer_if #(
  parameter int OPW = 4
);
  logic           run;
  logic [OPW-1:0] ir_opcode;
  logic [2:0]     t_state;
  logic           halted;
  logic           pc_out;
  logic           pc_inc;
  logic           mar_ei;
  logic           ram_out;
  logic           ir_ei;
  logic           ir_out;
  logic           a_ei;
  logic           a_out;
  logic           b_ei;
  logic           alu_out;
  logic           sub;
  logic           out_ei;

  modport master (
    input  run,
    input  ir_opcode,
    output t_state,
    output halted,
    output pc_out,
    output pc_inc,
    output mar_ei,
    output ram_out,
    output ir_ei,
    output ir_out,
    output a_ei,
    output a_out,
    output b_ei,
    output alu_out,
    output sub,
    output out_ei
  );

  modport slave (
    output run,
    output ir_opcode,
    input  t_state,
    input  halted,
    input  pc_out,
    input  pc_inc,
    input  mar_ei,
    input  ram_out,
    input  ir_ei,
    input  ir_out,
    input  a_ei,
    input  a_out,
    input  b_ei,
    input  alu_out,
    input  sub,
    input  out_ei
  );
endinterface

// File: rtl/control_sequencer.sv
// T-state fetch/decode/execute sequencer for the 8-bit bus CPU.
// Advances on the falling clk edge so strobes are settled at posedge.
module control_sequencer #(
  parameter int OPW       = 4,
  parameter bit SHORT_CYC = 1'b1
) (
  input  logic clk,
  input  logic rst,
  control_sequencer_if.master bus
);

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;

  localparam logic [OPW-1:0] OP_LDA = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0011);
  localparam logic [OPW-1:0] OP_OUT = OPW'(4'b1110);
  localparam logic [OPW-1:0] OP_HLT = OPW'(4'b1111);

  logic [2:0]     t_q;
  logic [2:0]     t_nxt;
  logic [OPW-1:0] op_q;
  logic           halted_q;

  logic is_lda;
  logic is_add;
  logic is_sub;
  logic is_out;
  logic is_alu;
  logic is_mem;
  logic en;

  assign is_lda = (op_q == OP_LDA);
  assign is_add = (op_q == OP_ADD);
  assign is_sub = (op_q == OP_SUB);
  assign is_out = (op_q == OP_OUT);
  assign is_alu = is_add | is_sub;
  assign is_mem = is_lda | is_alu;
  assign en     = ~rst & bus.run & ~halted_q;

  always_comb begin
    t_nxt = T0;
    case (t_q)
      T0: t_nxt = T1;
      T1: t_nxt = T2;
      T2: t_nxt = T3;
      T3: t_nxt = (SHORT_CYC && !is_mem) ? T0 : T4;
      T4: t_nxt = (SHORT_CYC && is_lda) ? T0 : T5;
      default: t_nxt = T0;
    endcase
  end

  // Opcode and halt are taken on the edge that leaves T2.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      t_q      <= T0;
      op_q     <= '0;
      halted_q <= 1'b0;
    end else if (bus.run && !halted_q) begin
      t_q <= t_nxt;
      if (t_q == T2) begin
        op_q <= bus.ir_opcode;
        if (bus.ir_opcode == OP_HLT)
          halted_q <= 1'b1;
      end
    end
  end

  logic s_pc_out;
  logic s_pc_inc;
  logic s_mar_ei;
  logic s_ram_out;
  logic s_ir_ei;
  logic s_ir_out;
  logic s_a_ei;
  logic s_a_out;
  logic s_b_ei;
  logic s_alu_out;
  logic s_sub;
  logic s_out_ei;

  always_comb begin
    s_pc_out  = 1'b0;
    s_pc_inc  = 1'b0;
    s_mar_ei  = 1'b0;
    s_ram_out = 1'b0;
    s_ir_ei   = 1'b0;
    s_ir_out  = 1'b0;
    s_a_ei    = 1'b0;
    s_a_out   = 1'b0;
    s_b_ei    = 1'b0;
    s_alu_out = 1'b0;
    s_sub     = 1'b0;
    s_out_ei  = 1'b0;
    unique case (1'b1)
      (t_q == T0): begin
        s_pc_out = 1'b1;
        s_mar_ei = 1'b1;
      end
      (t_q == T1): s_pc_inc = 1'b1;
      (t_q == T2): begin
        s_ram_out = 1'b1;
        s_ir_ei   = 1'b1;
      end
      (t_q == T3): begin
        s_ir_out = is_mem;
        s_mar_ei = is_mem;
        s_a_out  = is_out;
        s_out_ei = is_out;
      end
      (t_q == T4): begin
        s_ram_out = is_mem;
        s_a_ei    = is_lda;
        s_b_ei    = is_alu;
        s_sub     = is_sub;
      end
      (t_q == T5): begin
        s_alu_out = is_alu;
        s_a_ei    = is_alu;
        s_sub     = is_sub;
      end
      default: ;
    endcase
  end

  assign bus.t_state = t_q;
  assign bus.halted  = halted_q;
  assign bus.pc_out  = en & s_pc_out;
  assign bus.pc_inc  = en & s_pc_inc;
  assign bus.mar_ei  = en & s_mar_ei;
  assign bus.ram_out = en & s_ram_out;
  assign bus.ir_ei   = en & s_ir_ei;
  assign bus.ir_out  = en & s_ir_out;
  assign bus.a_ei    = en & s_a_ei;
  assign bus.a_out   = en & s_a_out;
  assign bus.b_ei    = en & s_b_ei;
  assign bus.alu_out = en & s_alu_out;
  assign bus.sub     = en & s_sub;
  assign bus.out_ei  = en & s_out_ei;

endmodule
